// File: rtl/instr_fetch_unit.sv
// Instruction-fetch front end: owns the PC and runs one valid/ready instruction-memory read
// at a time. It hands {instr, pc, pc_plus4} to decode and takes the resolved next PC back.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc_plus4,
  input  logic        ifid_ready,
  input  logic [31:0] next_pc,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        drop_q, drop_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic [31:0] ifid_pc_plus4_q, ifid_pc_plus4_d;
  logic        misalign_q, misalign_d;

  // A flush cycle never offers a request, so a redirect cannot race a newly accepted read.
  assign imem_req_valid = (state_q == REQ) && !flush;
  assign imem_req_addr  = pc_q;
  assign ifid_valid     = ifid_valid_q;
  assign ifid_instr     = ifid_instr_q;
  assign ifid_pc        = ifid_pc_q;
  assign ifid_pc_plus4  = ifid_pc_plus4_q;
  assign misalign_err   = misalign_q;

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    drop_d          = drop_q;
    ifid_valid_d    = ifid_valid_q;
    ifid_instr_d    = ifid_instr_q;
    ifid_pc_d       = ifid_pc_q;
    ifid_pc_plus4_d = ifid_pc_plus4_q;
    misalign_d      = misalign_q;

    if (flush) begin
      pc_d         = {flush_pc[31:2], 2'b00};
      ifid_valid_d = 1'b0;
      if (flush_pc[1:0] != 2'b00) misalign_d = 1'b1;
      if (state_q == WAIT) begin
        // The read in flight cannot be cancelled; swallow its response instead.
        if (imem_rsp_valid) begin
          drop_d  = 1'b0;
          state_d = REQ;
        end else begin
          drop_d = 1'b1;
        end
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        IDLE: state_d = REQ;
        REQ: begin
          if (imem_req_ready) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = REQ;
            end else begin
              ifid_instr_d    = imem_rsp_data;
              ifid_pc_d       = pc_q;
              ifid_pc_plus4_d = pc_q + 32'd4;
              ifid_valid_d    = 1'b1;
              state_d         = HOLD;
            end
          end
        end
        HOLD: begin
          if (ifid_ready) begin
            pc_d         = {next_pc[31:2], 2'b00};
            ifid_valid_d = 1'b0;
            if (next_pc[1:0] != 2'b00) misalign_d = 1'b1;
            state_d      = REQ;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q         <= IDLE;
      pc_q            <= RESET_PC;
      drop_q          <= 1'b0;
      ifid_valid_q    <= 1'b0;
      ifid_instr_q    <= 32'd0;
      ifid_pc_q       <= 32'd0;
      ifid_pc_plus4_q <= 32'd0;
      misalign_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      drop_q          <= drop_d;
      ifid_valid_q    <= ifid_valid_d;
      ifid_instr_q    <= ifid_instr_d;
      ifid_pc_q       <= ifid_pc_d;
      ifid_pc_plus4_q <= ifid_pc_plus4_d;
      misalign_q      <= misalign_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: drives the memory and decode sides by hand and
// checks outputs 1 ns after each rising edge against hand-computed values.
`timescale 1ns/1ps
module tb_instr_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        ifid_valid;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_ready;
  logic [31:0] next_pc;
  logic        flush;
  logic [31:0] flush_pc;
  logic        misalign_err;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .ifid_valid     (ifid_valid),
    .ifid_instr     (ifid_instr),
    .ifid_pc        (ifid_pc),
    .ifid_pc_plus4  (ifid_pc_plus4),
    .ifid_ready     (ifid_ready),
    .next_pc        (next_pc),
    .flush          (flush),
    .flush_pc       (flush_pc),
    .misalign_err   (misalign_err)
  );

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One accepted request followed by a response one cycle later.
  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  task automatic handoff(input logic [31:0] npc);
    ifid_ready = 1'b1;
    next_pc    = npc;
    step();
    ifid_ready = 1'b0;
  endtask

  initial begin
    RST = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    ifid_ready = 1'b0;
    next_pc    = 32'd0;
    flush      = 1'b0;
    flush_pc   = 32'd0;

    step();
    step();
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("rst_instr", ifid_instr, 32'd0);
    check("rst_pc", ifid_pc, 32'd0);
    check("rst_pc_plus4", ifid_pc_plus4, 32'd0);
    check("rst_misalign", {31'd0, misalign_err}, 32'd0);

    RST = 1'b0;
    step();
    check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);

    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2001_0005;
    step();
    imem_rsp_valid = 1'b0;
    check("f0_ifid_valid", {31'd0, ifid_valid}, 32'd1);
    check("f0_instr", ifid_instr, 32'h2001_0005);
    check("f0_pc", ifid_pc, 32'h0);
    check("f0_pc_plus4", ifid_pc_plus4, 32'h4);

    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", {31'd0, ifid_valid}, 32'd1);
      check("hold_instr", ifid_instr, 32'h2001_0005);
      check("hold_no_req", {31'd0, imem_req_valid}, 32'd0);
    end

    handoff(32'h0000_0040);
    check("ho_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("ho_req_addr", imem_req_addr, 32'h40);
    check("ho_ifid_valid", {31'd0, ifid_valid}, 32'd0);

    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("stall_req_addr", imem_req_addr, 32'h40);
      check("stall_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    end

    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    flush    = 1'b1;
    flush_pc = 32'h0000_0100;
    step();
    flush = 1'b0;
    check("flush_wait_req_valid", {31'd0, imem_req_valid}, 32'd0);
    step();
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("drop_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("drop_instr", ifid_instr, 32'h2001_0005);
    check("drop_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("drop_req_addr", imem_req_addr, 32'h100);

    fetch(32'h1111_1111);
    check("f1_instr", ifid_instr, 32'h1111_1111);
    check("f1_pc", ifid_pc, 32'h100);
    check("f1_pc_plus4", ifid_pc_plus4, 32'h104);
    check("f1_misalign", {31'd0, misalign_err}, 32'd0);

    handoff(32'h0000_0046);
    check("mis_req_addr", imem_req_addr, 32'h44);
    check("mis_err", {31'd0, misalign_err}, 32'd1);

    fetch(32'h2222_2222);
    check("f2_pc", ifid_pc, 32'h44);
    check("f2_pc_plus4", ifid_pc_plus4, 32'h48);

    handoff(32'hFFFF_FFFC);
    check("top_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    fetch(32'h3333_3333);
    check("top_instr", ifid_instr, 32'h3333_3333);
    check("top_pc", ifid_pc, 32'hFFFF_FFFC);
    check("top_pc_plus4_wrap", ifid_pc_plus4, 32'h0);
    check("top_misalign_sticky", {31'd0, misalign_err}, 32'd1);

    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h9999_9999;
    step();
    imem_rsp_valid = 1'b0;
    check("stray_rsp_instr", ifid_instr, 32'h3333_3333);
    check("stray_rsp_valid", {31'd0, ifid_valid}, 32'd1);

    RST = 1'b1;
    step();
    check("hold_rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    check("hold_rst_instr", ifid_instr, 32'd0);
    check("hold_rst_pc", ifid_pc, 32'd0);
    check("hold_rst_pc_plus4", ifid_pc_plus4, 32'd0);
    check("hold_rst_misalign", {31'd0, misalign_err}, 32'd0);
    check("hold_rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    RST = 1'b0;
    step();
    check("post_rst_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("post_rst_req_addr", imem_req_addr, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
